// File: rtl/ssd_window_sequencer.sv
// Window sequencer for the squared-difference MAC: reads win_len (a,b) pairs from two sync-read
// RAMs, feeds the MAC with aligned ce/sload, and returns the window sum on a valid/ready port.
module ssd_window_sequencer #(
  parameter int SIZEIN    = 8,
  parameter int SIZEOUT   = 20,
  parameter int AW        = 10,
  parameter int LW        = 10,
  parameter int SLOAD_DLY = 2,
  parameter int RES_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [LW-1:0]        win_len,
  output logic                 busy,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [SIZEIN-1:0]    rd_data_a,
  input  logic [SIZEIN-1:0]    rd_data_b,
  output logic [SIZEIN-1:0]    macc_a,
  output logic [SIZEIN-1:0]    macc_b,
  output logic                 macc_ce,
  output logic                 macc_sload,
  input  logic [SIZEOUT+1:0]   macc_accum,
  output logic [SIZEOUT+1:0]   res_data,
  output logic                 res_valid,
  input  logic                 res_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

  // Wide enough to hold RES_LAT and never collapse to zero bits.
  localparam int CW = $clog2(RES_LAT + 2);

  state_t             state_q, state_d;
  logic [LW-1:0]      rem_q;
  logic [CW-1:0]      drain_cnt_q;
  logic               pair_vld_q;
  logic               first_q;
  logic [SLOAD_DLY:0] sload_sr_q;
  logic               accept;
  logic               drain_done;

  assign accept     = (state_q == IDLE) && start;
  assign drain_done = (state_q == DRAIN) && (drain_cnt_q == CW'(RES_LAT));

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (win_len != '0) ? READ : HOLD;
      READ:    if (rem_q == LW'(1)) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ce covers the pair cycles (registered rd_en) and the whole drain up to the capture cycle.
  always_comb begin
    busy      = 1'b1;
    rd_en     = 1'b0;
    macc_ce   = pair_vld_q;
    res_valid = 1'b0;
    case (state_q)
      IDLE:    busy      = 1'b0;
      READ:    rd_en     = 1'b1;
      DRAIN:   macc_ce   = 1'b1;
      HOLD:    res_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // RAM outputs are already registered; gating them keeps drain cycles adding (0-0)^2.
  assign macc_a     = pair_vld_q ? rd_data_a : '0;
  assign macc_b     = pair_vld_q ? rd_data_b : '0;
  assign macc_sload = sload_sr_q[SLOAD_DLY];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr     <= '0;
      rem_q       <= '0;
      drain_cnt_q <= '0;
      pair_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      sload_sr_q  <= '0;
      res_data    <= '0;
    end else begin
      pair_vld_q    <= rd_en;
      // Bit 0 marks the cycle the first pair sits on macc_a/b.
      sload_sr_q[0] <= rd_en && first_q;
      for (int i = 1; i <= SLOAD_DLY; i++) sload_sr_q[i] <= sload_sr_q[i-1];
      drain_cnt_q   <= (state_q == DRAIN) ? drain_cnt_q + CW'(1) : '0;

      if (accept) begin
        rd_addr <= base_addr;
        rem_q   <= win_len;
        first_q <= 1'b1;
        if (win_len == '0) res_data <= '0;
      end

      if (state_q == READ) begin
        rd_addr <= rd_addr + AW'(1);
        rem_q   <= rem_q - LW'(1);
        first_q <= 1'b0;
      end

      if (drain_done) res_data <= macc_accum;
    end
  end

endmodule

// File: tb/tb_ssd_window_sequencer.sv
// Self-checking bench: sequencer plus bench-side RAMs and squared-difference MAC; every window
// is compared cycle by cycle against timing and sums derived from the block's documented rules.
module tb_ssd_window_sequencer;

  localparam int SLOAD_DLY = 2;
  localparam int RES_LAT   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [9:0]  win_len = '0;
  logic        busy, rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data_a, rd_data_b;
  logic [7:0]  macc_a, macc_b;
  logic        macc_ce, macc_sload;
  logic [21:0] macc_accum;
  logic [21:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic signed [7:0] mem_a [1024];
  logic signed [7:0] mem_b [1024];

  always #5 clk = ~clk;

  ssd_window_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .win_len    (win_len),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .macc_a     (macc_a),
    .macc_b     (macc_b),
    .macc_ce    (macc_ce),
    .macc_sload (macc_sload),
    .macc_accum (macc_accum),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  // Sync-read RAMs: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
  end

  // Squared-difference MAC with clock enable and registered sload.
  logic signed [7:0]  m_a_reg, m_b_reg;
  logic signed [8:0]  m_diff;
  logic signed [17:0] m_sq;
  logic               m_sload_reg;
  logic [21:0]        m_adder;

  always @(posedge clk) begin
    if (macc_ce) begin
      m_a_reg     <= macc_a;
      m_b_reg     <= macc_b;
      m_diff      <= m_a_reg - m_b_reg;
      m_sq        <= m_diff * m_diff;
      m_sload_reg <= macc_sload;
      m_adder     <= (m_sload_reg ? 22'd0 : m_adder) + 22'(m_sq);
    end
  end
  assign macc_accum = m_adder;

  function automatic logic [21:0] model_sum(input int base, input int len);
    longint s;
    int     d;
    s = 0;
    for (int i = 0; i < len; i++) begin
      d = int'(mem_a[(base + i) % 1024]) - int'(mem_b[(base + i) % 1024]);
      s += longint'(d * d);
    end
    return 22'(s);
  endfunction

  task automatic fill_random(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      mem_a[(base + i) % 1024] = 8'($urandom);
      mem_b[(base + i) % 1024] = 8'($urandom);
    end
  endtask

  // Starts a window at the current negedge and checks it cycle by cycle through the handshake.
  task automatic run_window(input string tag, input int base, input int len,
                            input logic [21:0] exp_sum, input int stall,
                            input bit poke_busy, input bit poke_hold);
    int         done_c;
    int         idx;
    logic [4:0] ctl_exp, ctl_obs;
    done_c    = (len == 0) ? 0 : len + RES_LAT + 1;
    start     = 1'b1;
    base_addr = 10'(base);
    win_len   = 10'(len);
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      start     = poke_busy && (c == 1);
      base_addr = 10'($urandom);
      win_len   = 10'($urandom);
      ctl_exp = {1'b1, c < len, (len != 0) && (c >= 1) && (c <= len + RES_LAT),
                 (len != 0) && (c == 1 + SLOAD_DLY), c == done_c};
      ctl_obs = {busy, rd_en, macc_ce, macc_sload, res_valid};
      vectors++;
      if (ctl_obs !== ctl_exp) begin
        miscompares++;
        $display("FAIL %s ctl c=%0d: got %b want %b (busy,rd_en,ce,sload,valid)", tag, c, ctl_obs, ctl_exp);
      end
      if (c < len) begin
        vectors++;
        if (rd_addr !== 10'(base + c)) begin
          miscompares++;
          $display("FAIL %s addr c=%0d: got %0d want %0d", tag, c, rd_addr, 10'(base + c));
        end
      end
      if (c >= 1 && c <= len) begin
        idx = (base + c - 1) % 1024;
        vectors++;
        if (macc_a !== mem_a[idx] || macc_b !== mem_b[idx]) begin
          miscompares++;
          $display("FAIL %s pair c=%0d: got a=%0d b=%0d want a=%0d b=%0d", tag, c,
                   $signed(macc_a), $signed(macc_b), mem_a[idx], mem_b[idx]);
        end
      end
      if (c == done_c) begin
        vectors++;
        if (res_data !== exp_sum) begin
          miscompares++;
          $display("FAIL %s result: got %0d want %0d", tag, res_data, exp_sum);
        end
      end
    end
    for (int h = 0; h < stall; h++) begin
      start     = poke_hold && (h == 2);
      base_addr = 10'($urandom);
      win_len   = 10'($urandom_range(1, 8));
      @(negedge clk);
      vectors++;
      if ({busy, rd_en, macc_ce, res_valid} !== 4'b1001 || res_data !== exp_sum) begin
        miscompares++;
        $display("FAIL %s hold h=%0d: busy,rd_en,ce,valid=%b res=%0d want 1001 res=%0d", tag, h,
                 {busy, rd_en, macc_ce, res_valid}, res_data, exp_sum);
      end
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++;
    if ({busy, rd_en, macc_ce, res_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s after handshake: busy,rd_en,ce,valid=%b want 0000", tag,
               {busy, rd_en, macc_ce, res_valid});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, rd_en, macc_ce, macc_sload, res_valid} !== 5'b0 || rd_addr !== 10'd0 ||
        macc_a !== 8'd0 || macc_b !== 8'd0 || res_data !== 22'd0) begin
      miscompares++;
      $display("FAIL reset: ctl=%b addr=%0d a=%0d b=%0d res=%0d want all zero",
               {busy, rd_en, macc_ce, macc_sload, res_valid}, rd_addr, macc_a, macc_b, res_data);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, rd_en, res_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset release: busy,rd_en,valid=%b want 000", {busy, rd_en, res_valid});
    end
  endtask

  task automatic test_single;
    mem_a[0] = 8'sd5;
    mem_b[0] = 8'sd2;
    run_window("t1_single", 0, 1, 22'd9, 0, 1'b0, 1'b0);
  endtask

  task automatic test_two_windows;
    mem_a[40] = 8'sd1;  mem_b[40] = 8'sd4;
    mem_a[41] = -8'sd3; mem_b[41] = 8'sd2;
    mem_a[42] = 8'sd7;  mem_b[42] = -8'sd1;
    mem_a[43] = 8'sd0;  mem_b[43] = 8'sd0;
    mem_a[50] = 8'sd1;  mem_b[50] = 8'sd0;
    run_window("t2_first", 40, 4, 22'd98, 1, 1'b0, 1'b0);
    run_window("t2_second", 50, 1, 22'd1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_full_range;
    for (int i = 20; i < 23; i++) begin
      mem_a[i] = 8'h80;
      mem_b[i] = 8'h7f;
    end
    run_window("t3_full_range", 20, 3, 22'd195075, 2, 1'b0, 1'b0);
  endtask

  task automatic test_hold_stall;
    fill_random(60, 2);
    run_window("t4_stall", 60, 2, model_sum(60, 2), 10, 1'b1, 1'b1);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL t4 start during hold was queued: busy=%b rd_en=%b want 0 0", busy, rd_en);
    end
  endtask

  task automatic test_zero_len;
    run_window("t5_zero_len", 123, 0, 22'd0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_wrap;
    fill_random(1022, 4);
    run_window("t6_wrap", 1022, 4, model_sum(1022, 4), 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort;
    fill_random(100, 20);
    start     = 1'b1;
    base_addr = 10'd100;
    win_len   = 10'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, rd_en, macc_ce, macc_sload, res_valid} !== 5'b0 || rd_addr !== 10'd0 ||
        macc_a !== 8'd0 || macc_b !== 8'd0 || res_data !== 22'd0) begin
      miscompares++;
      $display("FAIL abort reset: ctl=%b addr=%0d a=%0d b=%0d res=%0d want all zero",
               {busy, rd_en, macc_ce, macc_sload, res_valid}, rd_addr, macc_a, macc_b, res_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, rd_en, macc_ce, res_valid} !== 4'b0000) begin
        miscompares++;
        $display("FAIL abort idle i=%0d: busy,rd_en,ce,valid=%b want 0000", i,
                 {busy, rd_en, macc_ce, res_valid});
      end
    end
    fill_random(300, 6);
    run_window("t6_after_abort", 300, 6, model_sum(300, 6), 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    fill_random(500, 3);
    fill_random(700, 5);
    run_window("b2b_first", 500, 3, model_sum(500, 3), 0, 1'b0, 1'b0);
    run_window("b2b_second", 700, 5, model_sum(700, 5), 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    int base, len;
    for (int n = 0; n < 25; n++) begin
      base = $urandom_range(0, 1023);
      len  = (n % 7 == 3) ? 0 : $urandom_range(1, 24);
      fill_random(base, len);
      run_window("random", base, len, model_sum(base, len), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_windows();
    test_full_range();
    test_hold_stall();
    test_zero_len();
    test_wrap();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
